module_keypad_scanner: RTL

Active scanning front end for the 4x4 matrix keypad. The block drives one column low at a time and samples the four row lines. It debounces a detected press and emits a single-cycle `key_valid` pulse with a 4-bit key code, which is the value the capture/display path of the top consumes. It sits between the keypad pins and the digit-capture logic feeding the 7-segment multiplexer.

---
 rtl/module_keypad_scanner_if.sv | 28 ++
 rtl/module_keypad_scanner.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/module_keypad_scanner_if.sv
// Keypad pin bundle plus the decoded key outputs of the scanner.
// Latency: none, wires only.
// Backpressure: none; the keypad cannot be stalled and key_valid is a bare pulse.
interface module_keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] column;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  // Scanner side: samples the rows, drives strobes and key outputs.
  modport master (
    input  row,
    output column,
    output key_code,
    output key_valid,
    output key_held
  );

  // Keypad / consumer side.
  modport slave (
    output row,
    input  column,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/module_keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobing, 2-flop row sync, press/release debounce, key decode.
// Latency: press accepted one dwell end plus DEBOUNCE_CYCLES matches after the row syncs; release DEBOUNCE_CYCLES+3.
// Backpressure: none; key_valid is a one-cycle pulse that the consumer must take when offered.
module module_keypad_scanner #(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  module_keypad_scanner_if.master kp
);

  localparam int MAXP = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW   = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t        state, state_n;
  logic [3:0]    row_m, row_s;
  logic [1:0]    col_idx, col_idx_n;
  logic [3:0]    column_r;
  logic [CW-1:0] dwell, dwell_n;
  logic [CW-1:0] deb_cnt, deb_n;
  logic [3:0]    cap_row, cap_n;
  logic [3:0]    key_code_r, code_n;
  logic          key_valid_r, valid_n;
  logic          key_held_r, held_n;

  // Map (row, column) to the printed legend; * and # are encoded as E and F.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  // Index of the single low row; only called with a one-low pattern.
  function automatic logic [1:0] row_idx(input logic [3:0] rs);
    logic [1:0] r;
    case (rs)
      4'b1110: r = 2'd0;
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  function automatic logic one_low(input logic [3:0] rs);
    return (rs == 4'b1110) || (rs == 4'b1101) || (rs == 4'b1011) || (rs == 4'b0111);
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Next-state and next-output decisions for the scan/debounce FSM.
  always_comb begin
    state_n   = state;
    col_idx_n = col_idx;
    dwell_n   = dwell;
    deb_n     = deb_cnt;
    cap_n     = cap_row;
    code_n    = key_code_r;
    valid_n   = 1'b0;
    held_n    = key_held_r;
    case (state)
      SCAN: begin
        if (dwell == SCAN_LAST) begin
          dwell_n = '0;
          if (one_low(row_s)) begin
            state_n = DEBOUNCE;
            cap_n   = row_s;
            deb_n   = '0;
          end else begin
            col_idx_n = col_idx + 2'd1;
          end
        end else begin
          dwell_n = dwell + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (row_s == cap_row) begin
          if (deb_cnt == DEB_LAST) begin
            state_n = PRESSED;
            code_n  = key_map(row_idx(cap_row), col_idx);
            valid_n = 1'b1;
            held_n  = 1'b1;
            deb_n   = '0;
          end else begin
            deb_n = sat_inc(deb_cnt);
          end
        end else begin
          // Bounce or glitch: abandon this column and keep sweeping.
          state_n   = SCAN;
          col_idx_n = col_idx + 2'd1;
          dwell_n   = '0;
          deb_n     = '0;
        end
      end
      PRESSED: begin
        // Only an all-released sample counts, so a second key cannot retrigger.
        if (row_s == 4'hF) begin
          if (deb_cnt == DEB_LAST) begin
            state_n = RELEASE;
            deb_n   = '0;
          end else begin
            deb_n = sat_inc(deb_cnt);
          end
        end else begin
          deb_n = '0;
        end
      end
      RELEASE: begin
        state_n   = SCAN;
        held_n    = 1'b0;
        col_idx_n = col_idx + 2'd1;
        dwell_n   = '0;
      end
      default: state_n = SCAN;
    endcase
  end

  // State, counters, synchronizer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= SCAN;
      row_m       <= 4'hF;
      row_s       <= 4'hF;
      col_idx     <= 2'd0;
      column_r    <= 4'b1110;
      dwell       <= '0;
      deb_cnt     <= '0;
      cap_row     <= 4'hF;
      key_code_r  <= 4'h0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
    end else begin
      state       <= state_n;
      row_m       <= kp.row;
      row_s       <= row_m;
      col_idx     <= col_idx_n;
      column_r    <= ~(4'b0001 << col_idx_n);
      dwell       <= dwell_n;
      deb_cnt     <= deb_n;
      cap_row     <= cap_n;
      key_code_r  <= code_n;
      key_valid_r <= valid_n;
      key_held_r  <= held_n;
    end
  end

  assign kp.column    = column_r;
  assign kp.key_code  = key_code_r;
  assign kp.key_valid = key_valid_r;
  assign kp.key_held  = key_held_r;

endmodule
